// File: rtl/clock_ratio_monitor.sv
// Measures the period of a slow, asynchronous divided clock in clock cycles and
// reports whether it stays locked to an expected divide ratio.
//
// state  | meaning
// IDLE   | monitor disabled, all status cleared
// ARM    | waiting for a first mon_in rise to start timing
// TRACK  | timing periods, counting consecutive matches toward lock
// LOCKED | LOCK_COUNT consecutive matching periods seen
// FAULT  | bad period or timeout after lock; held until enable drops
module clock_ratio_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] expected_div,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [7:0]       mismatch_count
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [2:0] {IDLE, ARM, TRACK, LOCKED, FAULT} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic             rise;
  logic             match;
  logic [7:0]       mc_next;

  assign rise = s2 & ~s3;
  // A saturated count is a lost edge, and divide ratios below 2 are not measurable.
  assign match = (cnt == expected_div) && (cnt != CNT_MAX) &&
                 (expected_div[CNT_W-1:1] != '0);
  assign mc_next = (mismatch_count == 8'hFF) ? mismatch_count : mismatch_count + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      cnt            <= '0;
      match_cnt      <= '0;
      period         <= '0;
      period_valid   <= 1'b0;
      locked         <= 1'b0;
      fault          <= 1'b0;
      mismatch_count <= 8'd0;
    end else begin
      s1 <= mon_in;
      s2 <= s1;
      s3 <= s2;
      if (rise)
        cnt <= CNT_ONE;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_ONE;

      period_valid <= 1'b0;

      if (!enable) begin
        state          <= IDLE;
        match_cnt      <= '0;
        locked         <= 1'b0;
        fault          <= 1'b0;
        mismatch_count <= 8'd0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: if (rise) state <= TRACK;
          TRACK: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (match) begin
                match_cnt <= match_cnt + MW'(1);
                if (match_cnt == LOCK_LAST) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (!match) begin
                state          <= FAULT;
                locked         <= 1'b0;
                fault          <= 1'b1;
                mismatch_count <= mc_next;
              end
            end else if (cnt == CNT_MAX) begin
              state  <= FAULT;
              locked <= 1'b0;
              fault  <= 1'b1;
            end
          end
          FAULT: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (!match) mismatch_count <= mc_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Scoreboard bench for clock_ratio_monitor: stimulus queues the expected pulse
// contents, a negedge monitor pops and compares on every period_valid.
module tb_clock_ratio_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mon_in = 1'b0;
  logic [7:0] expected_div = 8'd8;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       fault;
  logic [7:0] mismatch_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] period;
    logic       locked;
    logic       fault;
    logic [7:0] mc;
  } exp_t;

  exp_t sb[$];

  clock_ratio_monitor #(.CNT_W(8), .LOCK_COUNT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .mon_in        (mon_in),
    .expected_div  (expected_div),
    .period        (period),
    .period_valid  (period_valid),
    .locked        (locked),
    .fault         (fault),
    .mismatch_count(mismatch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One mon_in pulse; if push is set, the rise at its start must report (p, l, f, mc).
  task automatic pulse(input int hi, input int lo, input bit push,
                       input logic [7:0] p, input bit l, input bit f, input logic [7:0] mc);
    exp_t e;
    if (push) begin
      e.period = p;
      e.locked = l;
      e.fault  = f;
      e.mc     = mc;
      sb.push_back(e);
    end
    mon_in = 1'b1;
    cycles(hi);
    mon_in = 1'b0;
    cycles(lo);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_mc"}, mismatch_count, 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && period_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got period=%0d, required no pulse", period);
      end else begin
        e = sb.pop_front();
        if (period !== e.period || locked !== e.locked || fault !== e.fault ||
            mismatch_count !== e.mc) begin
          fails++;
          $display("FAIL pulse: got period=%0d locked=%b fault=%b mc=%0d, required period=%0d locked=%b fault=%b mc=%0d",
                   period, locked, fault, mismatch_count, e.period, e.locked, e.fault, e.mc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cycles(1);
    check_all_zero("reset");

    // Lock at period 8: arm rise, then four matches, lock on the fourth.
    reset = 1'b0;
    enable = 1'b1;
    cycles(3);
    pulse(4, 4, 0, 0, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 1, 0, 0);
    pulse(4, 4, 1, 8, 1, 0, 0);
    // Short period of 7, measured at the following rise, then fault is sticky.
    pulse(4, 3, 1, 8, 1, 0, 0);
    pulse(4, 4, 1, 7, 0, 1, 1);
    pulse(4, 4, 1, 8, 0, 1, 1);
    pulse(4, 4, 1, 8, 0, 1, 1);
    check("sb_drained_fault", sb.size(), 0);

    // One-cycle enable drop clears status but keeps period.
    enable = 1'b0;
    cycles(1);
    check("dis_fault", fault, 0);
    check("dis_locked", locked, 0);
    check("dis_mc", mismatch_count, 0);
    check("dis_period_hold", period, 8);
    enable = 1'b1;
    cycles(2);
    pulse(4, 4, 0, 0, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 0, 0, 0);
    pulse(4, 4, 1, 8, 1, 0, 0);
    check("relock", locked, 1);

    // mon_in stops while locked: fault when the counter saturates, no pulse.
    cycles(200);
    check("timeout_early", fault, 0);
    k = 0;
    while (fault !== 1'b1 && k < 100) begin
      cycles(1);
      k++;
    end
    check("timeout_fault", fault, 1);
    check("timeout_locked", locked, 0);
    check("timeout_latency", k, 50);
    check("sb_drained_timeout", sb.size(), 0);

    // Period 4 against expected 8: pulses but never lock or count.
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    cycles(2);
    pulse(2, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) pulse(2, 2, 1, 4, 0, 0, 0);
    check("p4_locked", locked, 0);
    check("p4_fault", fault, 0);

    // Retarget expected_div to 4; takes effect at the next rise.
    expected_div = 8'd4;
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 1, 0, 0);
    pulse(2, 2, 1, 4, 1, 0, 0);
    check("sb_drained_p4", sb.size(), 0);

    // Reset mid-LOCKED clears everything at once; relock needs a fresh sequence.
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    cycles(2);
    reset = 1'b0;
    cycles(3);
    pulse(2, 2, 0, 0, 0, 0, 0);
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 0, 0, 0);
    pulse(2, 2, 1, 4, 1, 0, 0);
    cycles(5);
    check("sb_drained_end", sb.size(), 0);
    check("end_locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_ratio_monitor.md
CLOCK_RATIO_MONITOR -- requirements
Module: clock_ratio_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the period counter, expected_div and period.
REQ-002 Parameter LOCK_COUNT, default 4, sets the number of consecutive matching periods needed to lock.
REQ-003 Port clock, input, 1: system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: monitor run; low forces IDLE and clears all status.
REQ-006 Port mon_in, input, 1: divided clock under test, asynchronous to clock.
REQ-007 Port expected_div, input, CNT_W: expected mon_in period in clock cycles.
REQ-008 Port period, output, CNT_W: last measured rise-to-rise period.
REQ-009 Port period_valid, output, 1: one-cycle pulse when period updates.
REQ-010 Port locked, output, 1: high while the FSM is in LOCKED.
REQ-011 Port fault, output, 1: high while the FSM is in FAULT.
REQ-012 Port mismatch_count, output, 8: saturating count of bad periods seen after first lock.

Function
REQ-013 mon_in SHALL pass a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3.
REQ-014 All outputs SHALL be registered; a mon_in high first sampled at edge N yields period_valid high in the cycle after edge N+2.
REQ-015 The period counter SHALL load 1 on a rise cycle and otherwise increment, saturating at 2^CNT_W-1; a rise captures the counter value before the load, so rises P cycles apart measure P.
REQ-016 A saturated measurement SHALL never count as a match; expected_div of 0 or 1 SHALL never match.
REQ-017 expected_div SHALL be compared combinationally on each rise; a change takes effect at the next rise.
REQ-018 The FSM SHALL have states IDLE, ARM, TRACK, LOCKED and FAULT.
REQ-019 enable=0 SHALL move the FSM to IDLE from any state at the next edge and clear period_valid, locked, fault, mismatch_count and the match counter; period holds its value.
REQ-020 IDLE SHALL go to ARM when enable=1.
REQ-021 ARM SHALL go to TRACK on the first rise; that rise SHALL load the counter but produce no period_valid.
REQ-022 In TRACK, each rise SHALL pulse period_valid.
REQ-023 In TRACK, a matching rise SHALL increment the match counter; reaching LOCK_COUNT SHALL enter LOCKED.
REQ-024 In TRACK, a mismatching rise SHALL zero the match counter and stay in TRACK.
REQ-025 In LOCKED, each rise SHALL pulse period_valid; a mismatch SHALL enter FAULT and increment mismatch_count.
REQ-026 In LOCKED, a saturated period counter (timeout, mon_in stopped) SHALL enter FAULT without a period_valid pulse.
REQ-027 FAULT SHALL be sticky until enable=0 or reset; each rise in FAULT SHALL still pulse period_valid and increment mismatch_count on a mismatch.
REQ-028 mismatch_count SHALL saturate at 255.
REQ-029 When a rise coincides with enable falling, the enable=0 rule of REQ-019 SHALL take priority.

Reset
REQ-030 Asserting reset SHALL asynchronously force state IDLE, sync flops to 0, counters to 0, period=0, period_valid=0, locked=0, fault=0 and mismatch_count=0.
REQ-031 Reset SHALL be honoured mid-operation in any state; after release, with enable=1, the FSM SHALL restart from ARM.

Verification
REQ-032 mon_in 4 high / 4 low, expected_div=8, LOCK_COUNT=4 -> period=8 on each pulse; locked rises with the 5th rise's pulse; fault stays 0.
REQ-033 mon_in period 4, expected_div=8 -> period=4 pulses; locked and fault stay 0; mismatch_count stays 0.
REQ-034 Locked at period 8, then one period of 7 -> period=7, fault=1, locked=0, mismatch_count=1; later period-8 rises keep fault=1.
REQ-035 Locked, then mon_in held low -> no pulses; fault=1 once the counter reaches 255 (CNT_W=8).
REQ-036 In FAULT, drop enable for 1 cycle, then re-raise it -> fault=0 and mismatch_count=0; the monitor relocks after 1 arm rise plus 4 good rises.
REQ-037 Assert reset mid-LOCKED -> all outputs 0 immediately; after release, locked returns only after a fresh arm-and-track sequence.
